// File: rtl/i2c_minion_master_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_minion_master_seq_if                                             |
// | Request/response and open-drain pad bundle for the I2C sequencer.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface i2c_minion_master_seq_if #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 6
);
   logic                 start;
   logic                 rw;
   logic [ADDR_BITS-1:0] addr;
   logic [DATA_BITS-1:0] wdata;
   logic                 busy;
   logic                 done;
   logic                 ack_err;
   logic [DATA_BITS-1:0] rdata;
   logic                 scl_oe;
   logic                 sda_oe;
   logic                 sda_in;

   // master: on-chip requester plus the pad side; slave: the sequencer
   modport master (
      output start, rw, addr, wdata, sda_in,
      input  busy, done, ack_err, rdata, scl_oe, sda_oe
   );
   modport slave (
      input  start, rw, addr, wdata, sda_in,
      output busy, done, ack_err, rdata, scl_oe, sda_oe
   );
endinterface
`default_nettype wire

// File: rtl/i2c_minion_master_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_minion_master_seq                                                |
// | Single-transaction I2C master: START, addr, R/W, ACK, data, ACK, STOP|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module i2c_minion_master_seq #(
   parameter int CLK_DIV   = 4,
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   i2c_minion_master_seq_if.slave  bus
);

   localparam int c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
   localparam int c_BIT_W    = (c_MAX_BITS > 1) ? $clog2(c_MAX_BITS) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_BIT_W-1:0] c_ADDR_LAST = c_BIT_W'(ADDR_BITS - 1);
   localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_START = 4'd1,
      ST_ADDR  = 4'd2,
      ST_RW    = 4'd3,
      ST_ACK1  = 4'd4,
      ST_DATA  = 4'd5,
      ST_ACK2  = 4'd6,
      ST_STOP  = 4'd7,
      ST_DONE  = 4'd8
   } state_t;

   state_t                r_state;
   logic [c_DIV_W-1:0]    r_div;
   logic [1:0]            r_phase;
   logic [c_BIT_W-1:0]    r_bit;
   logic                  r_rw;
   logic [ADDR_BITS-1:0]  r_addr_sh;
   logic [DATA_BITS-1:0]  r_data_sh;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_ack_err;
   logic [DATA_BITS-1:0]  r_rdata;
   logic                  r_scl_oe;
   logic                  r_sda_oe;

   logic w_qtick;
   logic w_mid;
   logic w_sample;
   logic w_slot_end;

   assign w_qtick    = (r_div == c_DIV_LAST);
   assign w_mid      = w_qtick && (r_phase == 2'd1);
   assign w_sample   = w_qtick && (r_phase == 2'd2);
   assign w_slot_end = w_qtick && (r_phase == 2'd3);

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.ack_err = r_ack_err;
   assign bus.rdata   = r_rdata;
   assign bus.scl_oe  = r_scl_oe;
   assign bus.sda_oe  = r_sda_oe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_div     <= '0;
         r_phase   <= 2'd0;
         r_bit     <= '0;
         r_rw      <= 1'b0;
         r_addr_sh <= '0;
         r_data_sh <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_rdata   <= '0;
         r_scl_oe  <= 1'b0;
         r_sda_oe  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_div   <= '0;
               r_phase <= 2'd0;
               if (bus.start) begin
                  r_state   <= ST_START;
                  r_busy    <= 1'b1;
                  r_rw      <= bus.rw;
                  r_addr_sh <= bus.addr;
                  r_data_sh <= bus.wdata;
                  r_ack_err <= 1'b0;
                  r_scl_oe  <= 1'b0;
                  r_sda_oe  <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_div <= w_qtick ? '0 : r_div + 1'b1;
               if (w_qtick) begin
                  r_phase <= r_phase + 2'd1;
               end
               // Q2 entry: START pulls SDA low under high SCL, every other slot releases SCL
               if (w_mid) begin
                  if (r_state == ST_START) begin
                     r_sda_oe <= 1'b1;
                  end else begin
                     r_scl_oe <= 1'b0;
                  end
               end
               // Last clk of Q2: sample point; shift registers advance so MSB is the next bit
               if (w_sample) begin
                  case (r_state)
                     ST_ADDR: r_addr_sh <= r_addr_sh << 1;
                     ST_DATA: r_data_sh <= (r_data_sh << 1) | DATA_BITS'(r_rw & bus.sda_in);
                     ST_ACK1: if (bus.sda_in) r_ack_err <= 1'b1;
                     ST_ACK2: if (!r_rw && bus.sda_in) r_ack_err <= 1'b1;
                     ST_STOP: r_sda_oe <= 1'b0;
                     default: ;
                  endcase
               end
               if (w_slot_end) begin
                  case (r_state)
                     ST_START: begin
                        r_state  <= ST_ADDR;
                        r_bit    <= c_ADDR_LAST;
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= ~r_addr_sh[ADDR_BITS-1];
                     end
                     ST_ADDR: begin
                        r_scl_oe <= 1'b1;
                        if (r_bit == '0) begin
                           r_state  <= ST_RW;
                           r_sda_oe <= ~r_rw;
                        end else begin
                           r_bit    <= r_bit - 1'b1;
                           r_sda_oe <= ~r_addr_sh[ADDR_BITS-1];
                        end
                     end
                     ST_RW: begin
                        r_state  <= ST_ACK1;
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= 1'b0;
                     end
                     ST_ACK1: begin
                        r_scl_oe <= 1'b1;
                        if (r_ack_err) begin
                           r_state  <= ST_STOP;
                           r_sda_oe <= 1'b1;
                        end else begin
                           r_state  <= ST_DATA;
                           r_bit    <= c_DATA_LAST;
                           r_sda_oe <= ~r_rw & ~r_data_sh[DATA_BITS-1];
                        end
                     end
                     ST_DATA: begin
                        r_scl_oe <= 1'b1;
                        if (r_bit == '0) begin
                           r_state  <= ST_ACK2;
                           r_sda_oe <= 1'b0;
                        end else begin
                           r_bit    <= r_bit - 1'b1;
                           r_sda_oe <= ~r_rw & ~r_data_sh[DATA_BITS-1];
                        end
                     end
                     ST_ACK2: begin
                        r_state  <= ST_STOP;
                        r_scl_oe <= 1'b1;
                        r_sda_oe <= 1'b1;
                     end
                     ST_STOP: begin
                        r_state  <= ST_DONE;
                        r_scl_oe <= 1'b0;
                        r_sda_oe <= 1'b0;
                        r_done   <= 1'b1;
                        if (r_rw && !r_ack_err) begin
                           r_rdata <= r_data_sh;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire
